// File: rtl/pll_lock_supervisor_if.sv
// Status/control bundle between the PLL lock supervisor and its environment.
// The supervisor takes the master modport; the PLL/system side takes slave.
interface pll_lock_supervisor_if;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       timeout_err;
  logic [7:0] lock_lost_cnt;

  modport master (
    input  pll_locked,
    output pll_rst,
    output sys_rst,
    output ready,
    output timeout_err,
    output lock_lost_cnt
  );

  modport slave (
    output pll_locked,
    input  pll_rst,
    input  sys_rst,
    input  ready,
    input  timeout_err,
    input  lock_lost_cnt
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor: pulses pll_rst, waits for a stable lock, then releases sys_rst.
// Define PLL_SUP_AUTO_RELOCK_EN to re-pulse pll_rst when lock is lost while running.
module pll_lock_supervisor #(
  parameter int unsigned RST_PULSE_CYCLES = 16,
  parameter int unsigned STABLE_CYCLES    = 1024,
  parameter int unsigned LOCK_TIMEOUT     = 50000,
  parameter int unsigned MAX_RETRIES      = 3
) (
  input  logic                  refclk,
  input  logic                  rst,
  pll_lock_supervisor_if.master bus
);

  localparam int unsigned MaxAB    = (RST_PULSE_CYCLES > STABLE_CYCLES) ? RST_PULSE_CYCLES
                                                                        : STABLE_CYCLES;
  localparam int unsigned MaxCount = (MaxAB > LOCK_TIMEOUT) ? MaxAB : LOCK_TIMEOUT;
  localparam int unsigned CntW     = (MaxCount > 1) ? $clog2(MaxCount) : 1;

  localparam logic [CntW-1:0] RstLast    = CntW'(RST_PULSE_CYCLES - 1);
  localparam logic [CntW-1:0] StableLast = CntW'(STABLE_CYCLES - 1);
  localparam logic [CntW-1:0] LockLast   = CntW'(LOCK_TIMEOUT - 1);
  localparam logic [3:0]      RetryMax   = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    StPllRst,
    StWaitLock,
    StStable,
    StRun,
    StFail
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      retry_q, retry_d;
  logic [7:0]      lost_q, lost_d;
  logic            sync1_q, locked_s_q;
  logic            pll_rst_q, pll_rst_d;
  logic            sys_rst_q, sys_rst_d;
  logic            ready_q, ready_d;
  logic            timeout_err_q, timeout_err_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    lost_d  = lost_q;

    unique case (state_q)
      StPllRst: begin
        if (cnt_q == RstLast) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWaitLock: begin
        // Lock is checked first so it wins over a coincident timeout.
        if (locked_s_q) begin
          state_d = StStable;
          cnt_d   = '0;
        end else if (cnt_q == LockLast) begin
          retry_d = retry_q + 4'd1;
          state_d = (retry_d == RetryMax) ? StFail : StPllRst;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStable: begin
        if (!locked_s_q) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == StableLast) begin
          state_d = StRun;
          cnt_d   = '0;
          retry_d = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRun: begin
        if (!locked_s_q) begin
          if (lost_q != 8'hFF) begin
            lost_d = lost_q + 8'd1;
          end
`ifdef PLL_SUP_AUTO_RELOCK_EN
          state_d = StPllRst;
`else
          state_d = StWaitLock;
`endif
          cnt_d = '0;
        end
      end
      StFail: begin
        state_d = StFail;
      end
      default: begin
        state_d = StPllRst;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered from the next state so they change on the transition edge.
    pll_rst_d     = (state_d == StPllRst) || (state_d == StFail);
    sys_rst_d     = (state_d != StRun);
    ready_d       = (state_d == StRun);
    timeout_err_d = (state_d == StFail);
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync1_q       <= 1'b0;
      locked_s_q    <= 1'b0;
      state_q       <= StPllRst;
      cnt_q         <= '0;
      retry_q       <= '0;
      lost_q        <= '0;
      pll_rst_q     <= 1'b1;
      sys_rst_q     <= 1'b1;
      ready_q       <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      sync1_q       <= bus.pll_locked;
      locked_s_q    <= sync1_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_q       <= retry_d;
      lost_q        <= lost_d;
      pll_rst_q     <= pll_rst_d;
      sys_rst_q     <= sys_rst_d;
      ready_q       <= ready_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.pll_rst       = pll_rst_q;
  assign bus.sys_rst       = sys_rst_q;
  assign bus.ready         = ready_q;
  assign bus.timeout_err   = timeout_err_q;
  assign bus.lock_lost_cnt = lost_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor (RST_PULSE=4, STABLE=8, TIMEOUT=20, RETRIES=2).
// Inputs are driven and outputs sampled on the falling edge of refclk.
module tb_pll_lock_supervisor;

  logic refclk = 1'b0;
  logic rst    = 1'b1;
  int   n_cmp  = 0;
  int   n_err  = 0;

  pll_lock_supervisor_if bus ();

  pll_lock_supervisor #(
    .RST_PULSE_CYCLES(4),
    .STABLE_CYCLES   (8),
    .LOCK_TIMEOUT    (20),
    .MAX_RETRIES     (2)
  ) dut (
    .refclk(refclk),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 refclk = ~refclk;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cycles(input int k);
    repeat (k) @(negedge refclk);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    bus.pll_locked = 1'b0;
    cycles(3);
    rst = 1'b0;
  endtask

  // Negedges until ready equals v; -1 if the bound expires.
  task automatic wait_ready(input logic v, output int n);
    n = 0;
    while (bus.ready !== v && n < 500) begin
      @(negedge refclk);
      n++;
    end
    if (bus.ready !== v) n = -1;
  endtask

  // Negedges for which pll_rst stays at v; -1 if the bound expires.
  task automatic run_pll_rst(input logic v, output int n);
    n = 0;
    while (bus.pll_rst === v && n < 500) begin
      @(negedge refclk);
      n++;
    end
    if (n >= 500) n = -1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.pll_locked = 1'b1;
    cycles(2);
    n_cmp++; if (bus.pll_rst !== 1'b1) begin n_err++; $display("FAIL reset_pll_rst: got %b want 1", bus.pll_rst); end
    n_cmp++; if (bus.sys_rst !== 1'b1) begin n_err++; $display("FAIL reset_sys_rst: got %b want 1", bus.sys_rst); end
    n_cmp++; if (bus.ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", bus.ready); end
    n_cmp++; if (bus.timeout_err !== 1'b0) begin n_err++; $display("FAIL reset_timeout_err: got %b want 0", bus.timeout_err); end
    n_cmp++; if (bus.lock_lost_cnt !== 8'd0) begin n_err++; $display("FAIL reset_lost_cnt: got %0d want 0", bus.lock_lost_cnt); end
    bus.pll_locked = 1'b0;
  endtask

  task automatic test_normal_lock;
    int n;
    do_reset();
    run_pll_rst(1'b1, n);
    n_cmp++; if (n !== 4) begin n_err++; $display("FAIL normal_pulse_width: got %0d want 4", n); end
    cycles(3);
    bus.pll_locked = 1'b1;
    // 1 edge to sample, 2 sync edges, WAIT_LOCK->STABLE, 8 STABLE cycles.
    wait_ready(1'b1, n);
    n_cmp++; if (n !== 11) begin n_err++; $display("FAIL normal_ready_delay: got %0d want 11", n); end
    n_cmp++; if (bus.sys_rst !== 1'b0) begin n_err++; $display("FAIL normal_sys_rst: got %b want 0", bus.sys_rst); end
    n_cmp++; if (bus.pll_rst !== 1'b0) begin n_err++; $display("FAIL normal_pll_rst: got %b want 0", bus.pll_rst); end
    n_cmp++; if (bus.lock_lost_cnt !== 8'd0) begin n_err++; $display("FAIL normal_lost_cnt: got %0d want 0", bus.lock_lost_cnt); end
  endtask

  task automatic test_timeout_fail;
    int n;
    do_reset();
    run_pll_rst(1'b1, n);
    n_cmp++; if (n !== 4) begin n_err++; $display("FAIL to_pulse1: got %0d want 4", n); end
    run_pll_rst(1'b0, n);
    n_cmp++; if (n !== 20) begin n_err++; $display("FAIL to_wait1: got %0d want 20", n); end
    n_cmp++; if (bus.timeout_err !== 1'b0) begin n_err++; $display("FAIL to_early_fail: got %b want 0", bus.timeout_err); end
    run_pll_rst(1'b1, n);
    n_cmp++; if (n !== 4) begin n_err++; $display("FAIL to_pulse2: got %0d want 4", n); end
    run_pll_rst(1'b0, n);
    n_cmp++; if (n !== 20) begin n_err++; $display("FAIL to_wait2: got %0d want 20", n); end
    n_cmp++; if (bus.timeout_err !== 1'b1) begin n_err++; $display("FAIL to_timeout_err: got %b want 1", bus.timeout_err); end
    n_cmp++; if (bus.pll_rst !== 1'b1) begin n_err++; $display("FAIL to_pll_rst: got %b want 1", bus.pll_rst); end
    n_cmp++; if (bus.sys_rst !== 1'b1) begin n_err++; $display("FAIL to_sys_rst: got %b want 1", bus.sys_rst); end
    bus.pll_locked = 1'b1;
    cycles(30);
    n_cmp++; if (bus.timeout_err !== 1'b1) begin n_err++; $display("FAIL to_terminal_err: got %b want 1", bus.timeout_err); end
    n_cmp++; if (bus.ready !== 1'b0) begin n_err++; $display("FAIL to_terminal_ready: got %b want 0", bus.ready); end
  endtask

  // STABLE entered at edge 5 after release, so count 5 is seen at negedge 10.
  task automatic test_stable_glitch;
    int   n;
    logic saw;
    do_reset();
    bus.pll_locked = 1'b1;
    cycles(10);
    bus.pll_locked = 1'b0;
    cycles(1);
    bus.pll_locked = 1'b1;
    n   = 1;
    saw = 1'b0;
    while (bus.ready !== 1'b1 && n < 200) begin
      @(negedge refclk);
      n++;
      saw |= bus.pll_rst;
    end
    // Drop reaches STABLE 3 edges later, relock 3 edges after that, then 8 STABLE cycles.
    n_cmp++; if (n !== 12) begin n_err++; $display("FAIL glitch_ready_delay: got %0d want 12", n); end
    n_cmp++; if (saw !== 1'b0) begin n_err++; $display("FAIL glitch_pll_rst: got %b want 0", saw); end
    n_cmp++; if (bus.lock_lost_cnt !== 8'd0) begin n_err++; $display("FAIL glitch_lost_cnt: got %0d want 0", bus.lock_lost_cnt); end
  endtask

  // Starts in RUN, directly after test_stable_glitch.
  task automatic test_run_loss;
    int   n;
    logic saw;
    bus.pll_locked = 1'b0;
    wait_ready(1'b0, n);
    n_cmp++; if (n !== 3) begin n_err++; $display("FAIL loss_ready_delay: got %0d want 3", n); end
    n_cmp++; if (bus.sys_rst !== 1'b1) begin n_err++; $display("FAIL loss_sys_rst: got %b want 1", bus.sys_rst); end
    n_cmp++; if (bus.lock_lost_cnt !== 8'd1) begin n_err++; $display("FAIL loss_lost_cnt: got %0d want 1", bus.lock_lost_cnt); end
`ifdef PLL_SUP_AUTO_RELOCK_EN
    run_pll_rst(1'b1, n);
    n_cmp++; if (n !== 4) begin n_err++; $display("FAIL loss_relock_pulse: got %0d want 4", n); end
`else
    saw = bus.pll_rst;
    repeat (10) begin
      @(negedge refclk);
      saw |= bus.pll_rst;
    end
    n_cmp++; if (saw !== 1'b0) begin n_err++; $display("FAIL loss_no_pulse: got %b want 0", saw); end
`endif
    bus.pll_locked = 1'b1;
    wait_ready(1'b1, n);
    n_cmp++; if (n !== 11) begin n_err++; $display("FAIL loss_relock_delay: got %0d want 11", n); end
  endtask

  task automatic test_saturate;
    int n;
    int hung;
    hung = 0;
    do_reset();
    bus.pll_locked = 1'b1;
    wait_ready(1'b1, n);
    for (int i = 1; i <= 300; i++) begin
      bus.pll_locked = 1'b0;
      wait_ready(1'b0, n);
      if (n < 0) hung++;
      bus.pll_locked = 1'b1;
      wait_ready(1'b1, n);
      if (n < 0) hung++;
      if (i == 200) begin
        n_cmp++; if (bus.lock_lost_cnt !== 8'd200) begin n_err++; $display("FAIL sat_mid: got %0d want 200", bus.lock_lost_cnt); end
      end
    end
    n_cmp++; if (hung !== 0) begin n_err++; $display("FAIL sat_waits: got %0d expired want 0", hung); end
    n_cmp++; if (bus.lock_lost_cnt !== 8'd255) begin n_err++; $display("FAIL sat_final: got %0d want 255", bus.lock_lost_cnt); end
  endtask

  task automatic test_async_rst;
    int n;
    do_reset();
    n = 0;
    while (bus.timeout_err !== 1'b1 && n < 200) begin
      @(negedge refclk);
      n++;
    end
    n_cmp++; if (bus.timeout_err !== 1'b1) begin n_err++; $display("FAIL arst_reach_fail: got %b want 1", bus.timeout_err); end
    @(negedge refclk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (bus.timeout_err !== 1'b0) begin n_err++; $display("FAIL arst_fail_err: got %b want 0", bus.timeout_err); end
    n_cmp++; if (bus.pll_rst !== 1'b1) begin n_err++; $display("FAIL arst_fail_pll_rst: got %b want 1", bus.pll_rst); end
    n_cmp++; if (bus.sys_rst !== 1'b1) begin n_err++; $display("FAIL arst_fail_sys_rst: got %b want 1", bus.sys_rst); end
    @(negedge refclk);
    rst = 1'b0;
    bus.pll_locked = 1'b1;
    run_pll_rst(1'b1, n);
    n_cmp++; if (n !== 4) begin n_err++; $display("FAIL arst_pulse1: got %0d want 4", n); end
    // Locked already synchronized: STABLE at edge 5, RUN at edge 13.
    wait_ready(1'b1, n);
    n_cmp++; if (n !== 9) begin n_err++; $display("FAIL arst_ready1: got %0d want 9", n); end
    bus.pll_locked = 1'b0;
    wait_ready(1'b0, n);
    bus.pll_locked = 1'b1;
    wait_ready(1'b1, n);
    n_cmp++; if (bus.lock_lost_cnt !== 8'd1) begin n_err++; $display("FAIL arst_pre_lost: got %0d want 1", bus.lock_lost_cnt); end
    @(negedge refclk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (bus.ready !== 1'b0) begin n_err++; $display("FAIL arst_run_ready: got %b want 0", bus.ready); end
    n_cmp++; if (bus.sys_rst !== 1'b1) begin n_err++; $display("FAIL arst_run_sys_rst: got %b want 1", bus.sys_rst); end
    n_cmp++; if (bus.pll_rst !== 1'b1) begin n_err++; $display("FAIL arst_run_pll_rst: got %b want 1", bus.pll_rst); end
    n_cmp++; if (bus.lock_lost_cnt !== 8'd0) begin n_err++; $display("FAIL arst_run_lost: got %0d want 0", bus.lock_lost_cnt); end
    @(negedge refclk);
    rst = 1'b0;
    run_pll_rst(1'b1, n);
    n_cmp++; if (n !== 4) begin n_err++; $display("FAIL arst_pulse2: got %0d want 4", n); end
    wait_ready(1'b1, n);
    n_cmp++; if (n !== 9) begin n_err++; $display("FAIL arst_ready2: got %0d want 9", n); end
  endtask

  initial begin
    bus.pll_locked = 1'b0;
    test_reset();
    test_normal_lock();
    test_timeout_fail();
    test_stable_glitch();
    test_run_loss();
    test_saturate();
    test_async_rst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pll_lock_supervisor.md
PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 Parameter RST_PULSE_CYCLES, default 16: number of cycles pll_rst is held high per PLL reset pulse (minimum 1).
REQ-002 Parameter STABLE_CYCLES, default 1024: number of consecutive synchronized-locked cycles required before release (minimum 1).
REQ-003 Parameter LOCK_TIMEOUT, default 50000: number of cycles to wait for lock after each PLL reset pulse (1 ms at 50 MHz).
REQ-004 Parameter MAX_RETRIES, default 3: number of consecutive lock timeouts before entering FAIL (range 1..15).
REQ-005 refclk  input  1  50 MHz reference clock; the single clock of the block.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 pll_locked  input  1  PLL lock indicator, asynchronous to refclk.
REQ-008 pll_rst  output  1  reset to the PLL, active-high.
REQ-009 sys_rst  output  1  downstream system reset, active-high.
REQ-010 ready  output  1  high only in RUN.
REQ-011 timeout_err  output  1  high only in FAIL.
REQ-012 lock_lost_cnt  output  8  saturating count of lock losses seen while in RUN.

Function
REQ-013 pll_locked SHALL pass through a 2-flop synchronizer; locked_s lags pll_locked by 2 refclk edges, and all logic uses locked_s.
REQ-014 The FSM SHALL have the states PLL_RST, WAIT_LOCK, STABLE, RUN and FAIL, with one shared cycle counter cleared on every state entry.
REQ-015 In PLL_RST, pll_rst=1 for exactly RST_PULSE_CYCLES cycles, then the FSM goes to WAIT_LOCK.
REQ-016 In WAIT_LOCK, locked_s=1 SHALL go to STABLE.
REQ-017 In WAIT_LOCK, reaching counter==LOCK_TIMEOUT-1 with locked_s=0 SHALL increment retry_cnt, then go to FAIL if the new retry_cnt equals MAX_RETRIES, else go to PLL_RST.
REQ-018 In STABLE, locked_s=0 SHALL go to WAIT_LOCK (timeout restarts, retry_cnt unchanged).
REQ-019 In STABLE, reaching counter==STABLE_CYCLES-1 with locked_s=1 SHALL go to RUN, so STABLE lasts exactly STABLE_CYCLES cycles.
REQ-020 Entering RUN SHALL clear retry_cnt.
REQ-021 In RUN, locked_s=0 SHALL increment lock_lost_cnt (saturating at 255) and leave RUN per REQ-031/REQ-032.
REQ-022 FAIL SHALL be terminal until rst.
REQ-023 Outputs SHALL be decoded only from the registered state:
- pll_rst=1 in PLL_RST and FAIL.
- sys_rst=0 only in RUN.
- ready=1 only in RUN.
- timeout_err=1 only in FAIL.
REQ-024 sys_rst SHALL assert on the same edge on which RUN is exited; no glitch is permitted.
REQ-025 Counter width SHALL be clog2 of the largest of RST_PULSE_CYCLES, STABLE_CYCLES and LOCK_TIMEOUT; the counter SHALL never wrap within a state.
REQ-026 If a timeout and locked_s rise coincide in WAIT_LOCK, lock SHALL win (go to STABLE).

Reset
REQ-027 rst SHALL asynchronously force: state=PLL_RST, counter=0, retry_cnt=0, synchronizer flops=0, lock_lost_cnt=0.
REQ-028 While rst is high, outputs SHALL be pll_rst=1, sys_rst=1, ready=0, timeout_err=0, lock_lost_cnt=0.
REQ-029 rst asserted mid-operation (any state, including FAIL) SHALL abort immediately to the reset values.
REQ-030 After rst deasserts, a full RST_PULSE_CYCLES pulse SHALL be issued.

Configuration
REQ-031 With macro PLL_SUP_AUTO_RELOCK_EN defined, loss of lock in RUN SHALL go to PLL_RST (a fresh PLL reset pulse).
REQ-032 Without PLL_SUP_AUTO_RELOCK_EN, loss of lock in RUN SHALL go to WAIT_LOCK with no pll_rst pulse; the retry and timeout rules of REQ-017 still apply.

Verification (RST_PULSE_CYCLES=4, STABLE_CYCLES=8, LOCK_TIMEOUT=20, MAX_RETRIES=2)
REQ-033 Release rst and raise pll_locked 3 cycles after pll_rst falls -> pll_rst is high for exactly 4 cycles; sys_rst falls and ready rises 2+8 cycles after locked_s chain entry; lock_lost_cnt=0.
REQ-034 Hold pll_locked=0 -> two 4-cycle pll_rst pulses separated by 20-cycle waits, then FAIL: timeout_err=1, pll_rst=1 held, sys_rst=1.
REQ-035 In STABLE, drop pll_locked for 1 cycle at count 5 -> return to WAIT_LOCK; ready is delayed by a full 8 stable cycles after relock; no pll_rst pulse.
REQ-036 In RUN, drop pll_locked -> sys_rst=1 and ready=0 exactly 3 edges later; lock_lost_cnt=1; pll_rst pulses 4 cycles with the macro defined, none without it.
REQ-037 Force 300 lock losses in RUN -> lock_lost_cnt saturates at 255.
REQ-038 Assert rst in FAIL and in RUN -> outputs take reset values asynchronously; after release, a normal sequence completes.
